// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Definitions shared by the UART transmitter and receiver:
//            one-hot state encoding, oversampling ratio and default framing
//            and timing parameters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Oversampling ratio: one data bit spans this many baud ticks.
    localparam int OVERSAMPLE   = 16;

    // Defaults: 8 data bits, 1 stop bit, 19200 baud from a 50 MHz clock.
    localparam int DBIT_DEF     = 8;
    localparam int SB_TICK_DEF  = 16;
    localparam int CLK_DIV_DEF  = 163;
    localparam int DIV_W_DEF    = 8;

    // Tick counter width; wide enough for a 2-stop-bit count of 32.
    localparam int S_W          = 5;

    // One-hot framing states.
    localparam logic [3:0] IDLE  = 4'b0001;
    localparam logic [3:0] START = 4'b0010;
    localparam logic [3:0] DATA  = 4'b0100;
    localparam logic [3:0] STOP  = 4'b1000;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_gen
// Purpose  : Mod-CLK_DIV counter producing a one-cycle oversample tick.
// Ports    : clk    - system clock
//            reset  - synchronous active-high reset
//            clear  - synchronous restart of the count from zero
//            s_tick - high for one cycle when the count reaches CLK_DIV-1
// Revision : 1.0 - initial release
// ============================================================================
module baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic s_tick
);

    logic [DIV_W-1:0] r_div;

    assign s_tick = (r_div == DIV_W'(CLK_DIV - 1));

    // A clear restarts the period, so the first tick lands exactly CLK_DIV
    // cycles after the clearing cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_div <= '0;
        end else if (s_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

endmodule : baud_gen
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1-style UART transmitter, LSB first, 16x oversampled timing.
// Ports    : clk          - system clock
//            reset        - synchronous active-high reset
//            tx_start     - send request, honoured only while idle
//            din          - byte to send, latched on acceptance
//            tx           - serial line, idle high
//            tx_done_tick - one-cycle pulse at the end of the stop bit
//            tx_busy      - high from acceptance to the end of the stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_done_tick,
    output logic            tx_busy
);

    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic [3:0]      r_state, w_state_next;
    logic [S_W-1:0]  r_s,     w_s_next;
    logic [N_W-1:0]  r_n,     w_n_next;
    logic [DBIT-1:0] r_b,     w_b_next;
    logic            r_tx,    w_tx_next;
    logic            r_done,  w_done_next;
    logic            r_busy,  w_busy_next;
    logic            w_s_tick;
    logic            w_clear;

    // Restart bit timing on the acceptance cycle so every frame is exact.
    assign w_clear = (r_state == IDLE) && tx_start;

    baud_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .s_tick (w_s_tick)
    );

    // State and datapath registers; outputs are registered from next-state
    // values so they change in the same cycle the state does.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        case (r_state)
            IDLE: begin
                if (tx_start) begin
                    w_b_next     = din;
                    w_s_next     = '0;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_s_tick) begin
                    if (r_s == S_W'(OVERSAMPLE - 1)) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (w_s_tick) begin
                    if (r_s == S_W'(OVERSAMPLE - 1)) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        // Hold n on the last bit rather than letting it wrap.
                        if (r_n == N_W'(DBIT - 1)) begin
                            w_state_next = STOP;
                        end else begin
                            w_n_next = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (w_s_tick) begin
                    if (r_s == S_W'(SB_TICK - 1)) begin
                        w_state_next = IDLE;
                    end else begin
                        w_s_next = r_s + S_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state.
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_state_next != IDLE);
        w_done_next = (r_state == STOP) && (w_state_next == IDLE);
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_b_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx           = r_tx;
    assign tx_done_tick = r_done;
    assign tx_busy      = r_busy;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Two instances (1 and 2 stop
//            bits) share a monitor that rebuilds each expected frame from
//            the queued byte and compares the line cycle by cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CD       = 4;
    localparam int BIT_CLKS = 16 * CD;
    localparam int L0       = 9 * BIT_CLKS + 16 * CD;   // 640
    localparam int L1       = 9 * BIT_CLKS + 32 * CD;   // 704

    typedef struct {
        logic [7:0] d;
        bit         b2b;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start [2];
    logic [7:0] din   [2];
    logic       tx_o  [2];
    logic       done_o[2];
    logic       busy_o[2];

    exp_t exp_q   [2][$];
    logic wave    [2][$];
    bit   in_frame[2];
    bit   busy_ok [2];
    int   last_done[2];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_err    = 0;
    bit   fin      = 1'b0;
    bit   fin_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.DBIT(8), .SB_TICK(16), .CLK_DIV(CD), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .tx_start(start[0]), .din(din[0]),
        .tx(tx_o[0]), .tx_done_tick(done_o[0]), .tx_busy(busy_o[0]));

    uart_tx #(.DBIT(8), .SB_TICK(32), .CLK_DIV(CD), .DIV_W(8)) dut32 (
        .clk(clk), .reset(reset), .tx_start(start[1]), .din(din[1]),
        .tx(tx_o[1]), .tx_done_tick(done_o[1]), .tx_busy(busy_o[1]));

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int   len;
            int   bad;
            int   slot;
            logic expb;
            exp_t e;
            len = (g == 0) ? L0 : L1;
            if (reset) begin
                in_frame[g] = 1'b0;
            end else if (done_o[g] === 1'b1) begin
                n_vec++;
                if (!in_frame[g] || exp_q[g].size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected dut%0d: got pulse at cycle %0d, want none", g, cyc);
                end else begin
                    e = exp_q[g].pop_front();
                    if (wave[g].size() != len) begin
                        n_err++;
                        $display("FAIL frame_len dut%0d byte %02h: got %0d clocks, want %0d",
                                 g, e.d, wave[g].size(), len);
                    end else begin
                        bad = -1;
                        for (int i = 0; i < len; i++) begin
                            slot = i / BIT_CLKS;
                            if (slot == 0)      expb = 1'b0;
                            else if (slot <= 8) expb = e.d[slot-1];
                            else                expb = 1'b1;
                            if (wave[g][i] !== expb && bad < 0) bad = i;
                        end
                        n_vec++;
                        if (bad >= 0) begin
                            n_err++;
                            $display("FAIL frame_bits dut%0d byte %02h: clock %0d got %b want %b",
                                     g, e.d, bad, wave[g][bad], (bad / BIT_CLKS == 0) ? 1'b0 :
                                     (bad / BIT_CLKS <= 8) ? e.d[bad / BIT_CLKS - 1] : 1'b1);
                        end
                    end
                    n_vec++;
                    if (!busy_ok[g]) begin
                        n_err++;
                        $display("FAIL busy_in_frame dut%0d byte %02h: got busy low in frame, want high", g, e.d);
                    end
                end
                n_vec++;
                if (tx_o[g] !== 1'b1 || busy_o[g] !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_cycle dut%0d: got tx=%b busy=%b, want tx=1 busy=0",
                             g, tx_o[g], busy_o[g]);
                end
                in_frame[g]  = 1'b0;
                last_done[g] = cyc;
            end else if (in_frame[g]) begin
                wave[g].push_back(tx_o[g]);
                if (busy_o[g] !== 1'b1) busy_ok[g] = 1'b0;
            end else if (tx_o[g] === 1'b0) begin
                in_frame[g] = 1'b1;
                wave[g].delete();
                wave[g].push_back(1'b0);
                busy_ok[g] = (busy_o[g] === 1'b1);
                if (exp_q[g].size() > 0 && exp_q[g][0].b2b) begin
                    n_vec++;
                    if (cyc != last_done[g] + 1) begin
                        n_err++;
                        $display("FAIL b2b_gap dut%0d: got start %0d cycles after done, want 1",
                                 g, cyc - last_done[g]);
                    end
                end
            end else begin
                n_vec++;
                if (tx_o[g] !== 1'b1 || busy_o[g] !== 1'b0 || done_o[g] !== 1'b0) begin
                    n_err++;
                    $display("FAIL idle dut%0d cycle %0d: got tx=%b busy=%b done=%b, want 1 0 0",
                             g, cyc, tx_o[g], busy_o[g], done_o[g]);
                end
            end
        end
        if (fin && !fin_done) begin
            for (int g = 0; g < 2; g++) begin
                n_vec++;
                if (exp_q[g].size() != 0 || in_frame[g]) begin
                    n_err++;
                    $display("FAIL drain dut%0d: got %0d frames pending (in_frame=%b), want 0",
                             g, exp_q[g].size(), in_frame[g]);
                end
            end
            fin_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Pulse tx_start for one sampled edge; the byte is accepted on that edge.
    task automatic send(input int g, input logic [7:0] d, input bit b2b);
        exp_t e;
        @(posedge clk); #1;
        start[g] = 1'b1;
        din[g]   = d;
        @(posedge clk); #1;
        start[g] = 1'b0;
        e.d   = d;
        e.b2b = b2b;
        exp_q[g].push_back(e);
        din[g] = 8'($urandom);
    endtask

    // Send a byte and stay until just before its done cycle, disturbing
    // din / tx_start while busy (all of which must be ignored).
    task automatic run_frame(input int g, input logic [7:0] d, input bit b2b,
                             input int pulse_at, input bit glitch);
        int len;
        len = (g == 0) ? L0 : L1;
        send(g, d, b2b);
        for (int k = 1; k <= len - 1; k++) begin
            @(posedge clk); #1;
            if (k == pulse_at) begin
                start[g] = 1'b1;
                din[g]   = 8'hFF;
            end else begin
                start[g] = glitch && (k < len - 1) && ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) din[g] = 8'($urandom);
            end
        end
        start[g] = 1'b0;
    endtask

    initial begin
        int  g;
        int  prev_g;
        bit  b2b;
        for (int i = 0; i < 2; i++) begin
            start[i]     = 1'b0;
            din[i]       = 8'h00;
            in_frame[i]  = 1'b0;
            busy_ok[i]   = 1'b1;
            last_done[i] = -10;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(1000);

        run_frame(0, 8'hA5, 1'b0, -1, 1'b0);
        idle(20);
        run_frame(0, 8'h3C, 1'b0, 199, 1'b0);
        idle(20);
        run_frame(0, 8'hFF, 1'b0, -1, 1'b0);
        run_frame(0, 8'h00, 1'b1, -1, 1'b0);
        idle(20);

        // Reset in the middle of a frame: that byte never completes.
        send(0, 8'h55, 1'b0);
        repeat (299) @(posedge clk);
        #1 reset = 1'b1;
        void'(exp_q[0].pop_back());
        @(posedge clk);
        #1 reset = 1'b0;
        idle(30);
        run_frame(0, 8'h81, 1'b0, -1, 1'b0);
        idle(10);

        run_frame(1, 8'hF0, 1'b0, -1, 1'b0);
        idle(10);

        prev_g = -1;
        for (int i = 0; i < 10; i++) begin
            g   = int'($urandom_range(0, 1));
            b2b = (g == prev_g) && ($urandom_range(0, 1) == 1);
            if (!b2b) idle(int'($urandom_range(1, 20)));
            run_frame(g, 8'($urandom), b2b, -1, 1'b1);
            prev_g = g;
        end
        idle(10);

        fin = 1'b1;
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
